// File: rtl/shift_sequencer.sv
// Multi-byte in-place shifter: walks a little-endian operand in data memory,
// one byte every two cycles, steering the ALU shift / shift-overflow opcodes
// and writing each ALU result back to the byte it was read from.
module shift_sequencer #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dir,
   input  logic [2:0]        amount,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [7:0]        alu_op1,
   output logic [7:0]        alu_op2,
   output logic [3:0]        alu_operation,
   input  logic [7:0]        alu_result
);

   localparam logic [3:0] OP_RSHIFT = 4'd1;
   localparam logic [3:0] OP_LSHIFT = 4'd2;
   localparam logic [3:0] OP_SHO    = 4'd10;
   localparam logic [3:0] OP_NOP    = 4'd13;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      EXEC,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              dir_q;
   logic [2:0]        amount_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  count;
   logic [ADDR_W-1:0] cur_addr;
   logic              last_byte;

   assign last_byte = (count == len_q - LEN_W'(1));

   // State register; reset abandons any sequence in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand latch on accept, then byte pointer / counter advance after each write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir_q    <= 1'b0;
         amount_q <= '0;
         len_q    <= '0;
         count    <= '0;
         cur_addr <= '0;
      end else if (state == IDLE && start) begin
         dir_q    <= dir;
         amount_q <= amount;
         len_q    <= len;
         count    <= '0;
         // Right shifts walk from the most-significant byte downward.
         cur_addr <= dir ? base_addr + ADDR_W'(len) - ADDR_W'(1) : base_addr;
      end else if (state == EXEC) begin
         cur_addr <= dir_q ? cur_addr - ADDR_W'(1) : cur_addr + ADDR_W'(1);
         count    <= count + LEN_W'(1);
      end
   end

   // Next-state decode and per-state drive of the memory and ALU buses.
   always_comb begin
      state_next    = state;
      busy          = (state != IDLE);
      done          = 1'b0;
      rd_addr       = '0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      alu_op1       = '0;
      alu_op2       = '0;
      alu_operation = OP_NOP;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = (len == '0) ? DONE : READ;
            end
         end
         READ: begin
            rd_addr    = cur_addr;
            state_next = EXEC;
         end
         EXEC: begin
            alu_op1 = rd_data;
            alu_op2 = {5'b00000, amount_q};
            if (count == '0) begin
               alu_operation = dir_q ? OP_RSHIFT : OP_LSHIFT;
            end else begin
               alu_operation = OP_SHO;
            end
            wr_en      = 1'b1;
            wr_addr    = cur_addr;
            wr_data    = alu_result;
            state_next = last_byte ? DONE : READ;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural data memory and ALU (with overflow
// buffer), a write scoreboard fed by the stimulus process and drained by a
// negedge monitor, plus latency and final-memory checks.
module tb_shift_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       dir;
   logic [2:0] amount;
   logic [7:0] base_addr;
   logic [3:0] len;
   logic       busy;
   logic       done;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] alu_op1;
   logic [7:0] alu_op2;
   logic [3:0] alu_operation;
   logic [7:0] alu_result;

   int checks = 0;
   int errors = 0;

   shift_sequencer #(.ADDR_W(8), .LEN_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .amount(amount),
      .base_addr(base_addr), .len(len), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_operation(alu_operation), .alu_result(alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: 1-cycle read latency, write on wr_en, preload port for the bench.
   logic [7:0] mem [256];
   logic       pk_en;
   logic [7:0] pk_a;
   logic [7:0] pk_d;
   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
      else if (pk_en) mem[pk_a] <= pk_d;
   end

   // ALU: shifts and shift-with-overflow; overflow buffer and direction update on the edge.
   logic [7:0]  ovf;
   logic        ldir;
   logic [15:0] rw;
   logic [15:0] lw;
   always_comb begin
      rw = {alu_op1, 8'h00} >> alu_op2[2:0];
      lw = {8'h00, alu_op1} << alu_op2[2:0];
      case (alu_operation)
         4'd1:    alu_result = rw[15:8];
         4'd2:    alu_result = lw[7:0];
         4'd10:   alu_result = ldir ? (rw[15:8] | ovf) : (lw[7:0] | ovf);
         default: alu_result = 8'h00;
      endcase
   end
   always @(posedge clk) begin
      case (alu_operation)
         4'd1:  begin ovf <= rw[7:0];  ldir <= 1'b1; end
         4'd2:  begin ovf <= lw[15:8]; ldir <= 1'b0; end
         4'd10: ovf <= ldir ? rw[7:0] : lw[15:8];
         default: ;
      endcase
   end

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [3:0] op;
      logic [7:0] op2;
   } exp_t;
   exp_t q[$];

   task automatic expect_wr(input logic [7:0] a, input logic [7:0] d,
                            input logic [3:0] op, input logic [7:0] op2);
      exp_t e;
      e.addr = a; e.data = d; e.op = op; e.op2 = op2;
      q.push_back(e);
   endtask

   // Monitor: every write must match the head of the scoreboard; otherwise the ALU bus must idle.
   always @(negedge clk) begin
      if (rst) begin
         if (wr_en) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%02h data=%02h expected no write", wr_addr, wr_data);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data || alu_operation !== e.op || alu_op2 !== e.op2) begin
                  errors++;
                  $display("FAIL write got addr=%02h data=%02h op=%0d op2=%0d expected addr=%02h data=%02h op=%0d op2=%0d",
                           wr_addr, wr_data, alu_operation, alu_op2, e.addr, e.data, e.op, e.op2);
               end
            end
         end else begin
            checks++;
            if (alu_operation !== 4'd13) begin
               errors++;
               $display("FAIL idle_opcode got %0d expected 13", alu_operation);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(posedge clk);
      #1 pk_en = 1'b0;
   endtask

   // Presents start for exactly one sampling edge; returns 1 time unit after it.
   task automatic issue(input logic d, input logic [2:0] a, input logic [7:0] b, input logic [3:0] l);
      @(negedge clk);
      dir = d; amount = a; base_addr = b; len = l; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges (sampling edge = 1) until done is seen; returns in the DONE cycle.
   task automatic wait_done(input int exp_n, input int n0, input string name);
      int n = n0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for done after %0d edges", name, n);
      end else begin
         chk(name, n, exp_n);
      end
   endtask

   task automatic post_done(input string name);
      @(posedge clk);
      #1;
      chk({name, "_pulse"}, {busy, done}, 2'b00);
   endtask

   task automatic drained(input string name);
      chk({name, "_drained"}, q.size(), 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; dir = 1'b0; amount = '0; base_addr = '0; len = '0;
      pk_en = 1'b0; pk_a = '0; pk_d = '0; ovf = '0; ldir = 1'b0;
      #12;
      chk("rst_busy_done_wr", {busy, done, wr_en}, 3'b000);
      chk("rst_op", alu_operation, 4'd13);
      chk("rst_buses", {alu_op1, alu_op2, rd_addr, wr_addr, wr_data}, 40'h0);
      @(negedge clk) rst = 1'b1;

      // 1: left by 1, two bytes
      poke(8'h10, 8'h81); poke(8'h11, 8'h42);
      expect_wr(8'h10, 8'h02, 4'd2, 8'd1);
      expect_wr(8'h11, 8'h85, 4'd10, 8'd1);
      issue(1'b0, 3'd1, 8'h10, 4'd2);
      wait_done(5, 1, "t1_latency");
      post_done("t1");
      chk("t1_mem", {mem[8'h11], mem[8'h10]}, 16'h8502);
      drained("t1");

      // 2: right by 4, MSB first
      poke(8'h20, 8'h34); poke(8'h21, 8'h12);
      expect_wr(8'h21, 8'h01, 4'd1, 8'd4);
      expect_wr(8'h20, 8'h23, 4'd10, 8'd4);
      issue(1'b1, 3'd4, 8'h20, 4'd2);
      wait_done(5, 1, "t2_latency");
      post_done("t2");
      chk("t2_mem", {mem[8'h21], mem[8'h20]}, 16'h0123);
      drained("t2");

      // 3: zero length
      issue(1'b0, 3'd3, 8'h70, 4'd0);
      wait_done(1, 1, "t3_latency");
      post_done("t3");
      drained("t3");

      // 4: address wrap
      poke(8'hFF, 8'hF0); poke(8'h00, 8'h01);
      expect_wr(8'hFF, 8'h80, 4'd2, 8'd3);
      expect_wr(8'h00, 8'h0F, 4'd10, 8'd3);
      issue(1'b0, 3'd3, 8'hFF, 4'd2);
      wait_done(5, 1, "t4_latency");
      post_done("t4");
      chk("t4_mem", {mem[8'h00], mem[8'hFF]}, 16'h0F80);
      drained("t4");

      // 5: start while busy ignored; start held through DONE only accepted from IDLE
      poke(8'h50, 8'h55); poke(8'h51, 8'hAA); poke(8'h60, 8'h80);
      expect_wr(8'h50, 8'h54, 4'd2, 8'd2);
      expect_wr(8'h51, 8'hA9, 4'd10, 8'd2);
      issue(1'b0, 3'd2, 8'h50, 4'd2);
      @(negedge clk);
      dir = 1'b1; amount = 3'd7; base_addr = 8'h60; len = 4'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(5, 2, "t5a_latency");
      chk("t5a_mem", {mem[8'h51], mem[8'h50], mem[8'h60]}, 24'hA95480);
      drained("t5a");
      expect_wr(8'h60, 8'h01, 4'd1, 8'd7);
      start = 1'b1;
      @(posedge clk);
      #1 chk("t5_idle_after_done", {busy, done}, 2'b00);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(3, 1, "t5b_latency");
      post_done("t5b");
      chk("t5b_mem", mem[8'h60], 8'h01);
      drained("t5b");

      // 6: reset in the second EXEC of a 4-byte op, then a fresh op
      poke(8'h30, 8'h11); poke(8'h31, 8'h22); poke(8'h32, 8'h33); poke(8'h33, 8'h44);
      expect_wr(8'h30, 8'h22, 4'd2, 8'd1);
      issue(1'b0, 3'd1, 8'h30, 4'd4);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_busy_wr", {busy, wr_en}, 2'b00);
      chk("t6_rst_op", alu_operation, 4'd13);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 chk("t6_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h44332222);
      drained("t6");
      poke(8'h40, 8'h0C); poke(8'h41, 8'hF0);
      expect_wr(8'h41, 8'h3C, 4'd1, 8'd2);
      expect_wr(8'h40, 8'h03, 4'd10, 8'd2);
      issue(1'b1, 3'd2, 8'h40, 4'd2);
      wait_done(5, 1, "t6b_latency");
      post_done("t6b");
      chk("t6b_mem", {mem[8'h41], mem[8'h40]}, 16'h3C03);
      drained("t6b");

      // 7: zero shift amount rewrites unchanged
      poke(8'h48, 8'hA5);
      expect_wr(8'h48, 8'hA5, 4'd2, 8'd0);
      issue(1'b0, 3'd0, 8'h48, 4'd1);
      wait_done(3, 1, "t7_latency");
      post_done("t7");
      chk("t7_mem", mem[8'h48], 8'hA5);
      drained("t7");

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
